mem_line_arbiter: RTL and testbench
===================================

# mem_line_arbiter

Sequences four-word cache-line transfers between two cache controllers (requester 0 = I-cache, requester 1 = D-cache) and one shared four-bank memory. It arbitrates round-robin and issues one word per bank in order, skipping no bank and stalling on bank busy. It tracks read returns through the fixed memory latency and pulses a per-requester done. It sits between the cache controllers' memory ports and the four-bank memory.

## Interface
Parameters:
- ADDR_W, 16, address width (word-addressed by byte, bit 0 always 0)
- DATA_W, 16, data width
- RD_LAT, 2, cycles from accepted mem_rd to valid mem_data_out

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_rd  in  2  per-requester line-read request, held until done
- req_wr  in  2  per-requester line-write request, held until done
- req_addr0, req_addr1  in  ADDR_W  line address; bits [2:0] ignored
- wr_data0, wr_data1  in  DATA_W  write word for current `beat`, driven combinationally by requester
- grant  out  2  one-hot owner, held for whole transaction
- beat  out  2  bank/word index being issued
- rd_valid  out  1  read word valid to granted requester
- rd_beat  out  2  word index of rd_data
- rd_data  out  DATA_W  returned word
- done  out  2  one-cycle completion pulse to owner
- err  out  2  one-cycle error pulse
- mem_addr  out  ADDR_W  {line[ADDR_W-1:3], beat, 1'b0}
- mem_data_in  out  DATA_W  owner's wr_data
- mem_rd, mem_wr  out  1  access strobes
- mem_data_out  in  DATA_W  read data
- mem_busy  in  4  per-bank busy
- mem_err  in  1  memory error

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset: state IDLE; grant, beat, rd_valid, rd_beat, rd_data, done, err, mem_rd, mem_wr = 0; mem_addr, mem_data_in = 0; rr pointer = 0 (requester 0 favoured); return pipe and sticky error cleared.
- IDLE:
  - Requester i is eligible when exactly one of req_rd[i] and req_wr[i] is set.
  - If both are set, err[i] pulses every cycle they are held and i is not granted.
  - If both requesters are eligible, the pointer side wins. Otherwise the sole eligible requester wins.
  - The winner, op, and line address are latched. Go to ISSUE with beat = 0.
- ISSUE:
  - If mem_busy[beat] = 0, assert mem_rd or mem_wr with mem_addr and increment beat. Otherwise hold beat with no strobe.
  - After beat 3 is issued, a write goes to DONE and a read goes to DRAIN.
- Read return: an RD_LAT-deep shift pipe of {valid, beat}. At pipe head, rd_valid = 1, rd_beat = tag, rd_data = mem_data_out.
- DRAIN: wait until the fourth return has been presented, then go to DONE.
- DONE:
  - done[owner] = 1; err[owner] = sticky error.
  - Grant drops the next cycle; pointer := other requester; go to IDLE.
- mem_err in any non-IDLE cycle sets the sticky error. The transaction still completes all four beats.
- Requester changes to req_*/req_addr during a transaction are ignored. Only the latched values are used.
- Reset mid-transaction abandons it: no done, in-flight returns are discarded (pipe cleared), and the requester must re-request.

## Timing
- Request seen in IDLE at cycle 0. grant and ISSUE from cycle 1.
- No busy: beats issue cycles 1–4.
  - Write: DONE (done pulse) at cycle 5, IDLE at cycle 6.
  - Read: returns at cycles 3–6, DRAIN at cycles 5–6, done at cycle 7, IDLE at cycle 8.
- Each busy cycle on the addressed bank adds one cycle.
- Back-to-back: a new grant can be made in the IDLE cycle right after DONE. There is a minimum one idle cycle between transactions.
- The done cycle is never concurrent with rd_valid.

## Structure
- Shared package (`mem_arb_pkg`): state encodings, REQ_ICACHE = 0, REQ_DCACHE = 1, RD_LAT, WORDS_PER_LINE = 4.
- Sub-module `mem_rd_tracker`: RD_LAT-stage {valid, beat} pipe with a return counter. It outputs rd_valid, rd_beat, and last_return.

## Test plan
- Single read, req_rd = 2'b01, addr 0x0128, no busy: mem_addr 0x0128, 0x012A, 0x012C, 0x012E at cycles 1–4; rd_valid cycles 3–6 with rd_beat 0–3; done = 2'b01 at cycle 7.
- Simultaneous req_wr[0] and req_rd[1] after reset: requester 0 granted first (done cycle 5). Requester 1 is granted in the next IDLE and finishes with done = 2'b10. The following contention goes to requester 0 again.
- mem_busy[2] high for 3 cycles during a read: beat 2 issue is delayed 3 cycles, and done arrives at cycle 10.
- req_rd[1] and req_wr[1] both set: err = 2'b10 each cycle, no grant, no mem strobe.
- mem_err pulsed at cycle 2 of a write: all four mem_wr still issue; done[0] and err[0] both pulse at cycle 5.
- rst at cycle 4 of a read: the next cycle shows all outputs 0, no rd_valid follows, and the pointer returns to 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache-line memory arbiter: FSM encoding,
// requester indices and line geometry.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic REQ_ICACHE     = 1'b0;
    localparam logic REQ_DCACHE     = 1'b1;
    localparam int   RD_LAT         = 2;
    localparam int   WORDS_PER_LINE = 4;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_rd_tracker.sv
// Follows accepted reads through the fixed memory latency and flags the
// presentation of the last word of a line.
module mem_rd_tracker #(
    parameter int RD_LAT = mem_arb_pkg::RD_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [1:0] push_beat_i,
    output logic       rd_valid_o,
    output logic [1:0] rd_beat_o,
    output logic       last_return_o
);
    import mem_arb_pkg::*;

    logic [RD_LAT-1:0] vld_q;
    logic [1:0]        tag_q [RD_LAT];
    logic [1:0]        cnt_q;

    // Latency pipe of {valid, beat} plus count of returns presented
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= 2'b00;
            end
            cnt_q <= 2'b00;
        end else begin
            vld_q[0] <= push_i;
            tag_q[0] <= push_beat_i;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
            if (vld_q[RD_LAT-1]) begin
                cnt_q <= cnt_q + 2'd1;
            end else begin
                cnt_q <= cnt_q;
            end
        end
    end

    assign rd_valid_o    = vld_q[RD_LAT-1];
    assign rd_beat_o     = vld_q[RD_LAT-1] ? tag_q[RD_LAT-1] : 2'b00;
    assign last_return_o = vld_q[RD_LAT-1] && (cnt_q == 2'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sequencing four-word line transfers from the I-cache
// and D-cache onto a shared four-bank memory.
module mem_line_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = mem_arb_pkg::RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_rd,
    input  logic [1:0]        req_wr,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic [1:0]        grant,
    output logic [1:0]        beat,
    output logic              rd_valid,
    output logic [1:0]        rd_beat,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic [3:0]        mem_busy,
    input  logic              mem_err
);
    import mem_arb_pkg::*;

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              owner_q, owner_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-4:0] line_q, line_d;
    logic [1:0]        beat_q, beat_d;
    logic              ptr_q, ptr_d;
    logic              sticky_q, sticky_d;

    logic [1:0] elig_s;
    logic       win_s;
    logic       issue_s;
    logic       last_return_s;
    logic       addr_unused_s;

    // Word offset bits of the line address carry no information
    assign addr_unused_s = ^{req_addr0[2:0], req_addr1[2:0]};

    assign elig_s  = req_rd ^ req_wr;
    assign issue_s = (state_q == ST_ISSUE) && !mem_busy[beat_q];

    // Winner selection: pointer side breaks a tie
    always_comb begin
        win_s = REQ_ICACHE;
        if (elig_s == 2'b11) begin
            win_s = ptr_q;
        end else if (elig_s[0]) begin
            win_s = REQ_ICACHE;
        end else begin
            win_s = REQ_DCACHE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (elig_s != 2'b00) state_d = ST_ISSUE;
                else                 state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (issue_s && (beat_q == 2'd3)) state_d = op_wr_q ? ST_DONE : ST_DRAIN;
                else                             state_d = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (last_return_s) state_d = ST_DONE;
                else               state_d = ST_DRAIN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Transaction context next-state
    always_comb begin
        grant_d  = grant_q;
        owner_d  = owner_q;
        op_wr_d  = op_wr_q;
        line_d   = line_q;
        beat_d   = beat_q;
        ptr_d    = ptr_q;
        sticky_d = sticky_q;
        if (state_q != ST_IDLE && mem_err) sticky_d = 1'b1;
        else                               sticky_d = sticky_q;
        case (state_q)
            ST_IDLE: begin
                if (elig_s != 2'b00) begin
                    grant_d  = req_onehot(win_s);
                    owner_d  = win_s;
                    op_wr_d  = req_wr[win_s];
                    line_d   = win_s ? req_addr1[ADDR_W-1:3] : req_addr0[ADDR_W-1:3];
                    beat_d   = 2'b00;
                    sticky_d = 1'b0;
                end else begin
                    grant_d = 2'b00;
                end
            end
            ST_ISSUE: begin
                if (issue_s) beat_d = beat_q + 2'd1;
                else         beat_d = beat_q;
            end
            ST_DONE: begin
                grant_d  = 2'b00;
                ptr_d    = ~owner_q;
                sticky_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Transaction context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q  <= 2'b00;
            owner_q  <= 1'b0;
            op_wr_q  <= 1'b0;
            line_q   <= '0;
            beat_q   <= 2'b00;
            ptr_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            op_wr_q  <= op_wr_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
            ptr_q    <= ptr_d;
            sticky_q <= sticky_d;
        end
    end

    // Output decode; a memory error in the done cycle itself is still reported
    always_comb begin
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        done        = 2'b00;
        err         = 2'b00;
        case (state_q)
            ST_IDLE: err = req_rd & req_wr;
            ST_ISSUE: begin
                mem_addr = {line_q, beat_q, 1'b0};
                mem_rd   = issue_s & ~op_wr_q;
                mem_wr   = issue_s & op_wr_q;
                if (op_wr_q) mem_data_in = owner_q ? wr_data1 : wr_data0;
                else         mem_data_in = '0;
            end
            ST_DONE: begin
                done = grant_q;
                if (sticky_q || mem_err) err = grant_q;
                else                     err = 2'b00;
            end
            default: ;
        endcase
    end

    mem_rd_tracker #(.RD_LAT(RD_LAT)) u_rd_tracker (
        .clk           (clk),
        .rst           (rst),
        .push_i        (mem_rd),
        .push_beat_i   (beat_q),
        .rd_valid_o    (rd_valid),
        .rd_beat_o     (rd_beat),
        .last_return_o (last_return_s)
    );

    assign grant   = grant_q;
    assign beat    = beat_q;
    assign rd_data = rd_valid ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_mem_line_arbiter;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_rd, req_wr;
    logic [15:0] req_addr0, req_addr1, wr_data0, wr_data1;
    logic [1:0]  grant, beat, rd_beat, done, err;
    logic        rd_valid, mem_rd, mem_wr, mem_err;
    logic [15:0] rd_data, mem_addr, mem_data_in, mem_data_out;
    logic [3:0]  mem_busy;

    int checks = 0;
    int errors = 0;
    logic mp;
    int dc;

    always #5 clk = ~clk;

    mem_line_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .grant(grant), .beat(beat), .rd_valid(rd_valid), .rd_beat(rd_beat),
        .rd_data(rd_data), .done(done), .err(err), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out), .mem_busy(mem_busy), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rand(input int busy_pct, input int err_pct);
        for (int b = 0; b < 4; b++) mem_busy[b] = ($urandom_range(99) < busy_pct);
        mem_err      = ($urandom_range(99) < err_pct);
        mem_data_out = 16'($urandom);
        wr_data0     = 16'($urandom);
        wr_data1     = 16'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, grant, 2'b00);
        chk({tag, "_beat"}, beat, 2'b00);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_rd_beat"}, rd_beat, 2'b00);
        chk({tag, "_rd_data"}, rd_data, 16'h0000);
        chk({tag, "_done"}, done, 2'b00);
        chk({tag, "_err"}, err, 2'b00);
        chk({tag, "_mem_rd"}, mem_rd, 1'b0);
        chk({tag, "_mem_wr"}, mem_wr, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
        chk({tag, "_mem_data_in"}, mem_data_in, 16'h0000);
    endtask

    // One IDLE decision cycle followed by the granted transaction (if any)
    task automatic run_txn(input logic [1:0] rd, input logic [1:0] wr,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input int busy_pct, input int err_pct, input int err_at,
                           input int b2_stall, input int abort_at, output int done_c);
        logic [1:0]  elig, oh;
        logic        own, is_wr, sticky, exp_s;
        logic [12:0] line;
        int          issued, done_exp;
        int          rt_c[$];
        logic [1:0]  rt_b[$];
        done_c = -1;
        @(posedge clk); #1;
        req_rd = rd; req_wr = wr; req_addr0 = a0; req_addr1 = a1;
        drive_rand(busy_pct, err_pct);
        @(negedge clk);
        chk("idle_err", err, rd & wr);
        chk("idle_grant", grant, 2'b00);
        chk("idle_mem_rd", mem_rd, 1'b0);
        chk("idle_mem_wr", mem_wr, 1'b0);
        chk("idle_done", done, 2'b00);
        elig = rd ^ wr;
        if (elig == 2'b00) return;
        own    = (elig == 2'b11) ? mp : (elig[0] ? 1'b0 : 1'b1);
        oh     = own ? 2'b10 : 2'b01;
        is_wr  = wr[own];
        line   = own ? a1[15:3] : a0[15:3];
        issued = 0; sticky = 1'b0; done_exp = -1;
        for (int c = 1; c < 200; c++) begin
            @(posedge clk); #1;
            if (c == abort_at) begin
                rst = 1'b1; req_rd = 2'b00; req_wr = 2'b00; mem_busy = 4'h0; mem_err = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check_all_zero("post_rst");
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk); #1;
                    mem_data_out = 16'($urandom);
                    @(negedge clk);
                    chk("post_rst_rd_valid", rd_valid, 1'b0);
                    chk("post_rst_grant", grant, 2'b00);
                    chk("post_rst_mem_rd", mem_rd, 1'b0);
                end
                mp = 1'b0;
                return;
            end
            drive_rand(busy_pct, err_pct);
            if (b2_stall > 0 && issued == 2) begin
                mem_busy = 4'b0100;
                b2_stall--;
            end
            if (err_at >= 0) mem_err = (c == err_at);
            req_addr0 = 16'($urandom); req_addr1 = 16'($urandom);
            @(negedge clk);
            if (done != 2'b00 && done_c < 0) done_c = c;
            chk("grant", grant, oh);
            exp_s = (issued < 4) && !mem_busy[issued[1:0]];
            chk("mem_rd", mem_rd, exp_s && !is_wr);
            chk("mem_wr", mem_wr, exp_s && is_wr);
            if (issued < 4) chk("beat", beat, issued[1:0]);
            if (exp_s) begin
                chk("mem_addr", mem_addr, {line, issued[1:0], 1'b0});
                if (is_wr) begin
                    chk("mem_data_in", mem_data_in, own ? wr_data1 : wr_data0);
                end else begin
                    rt_c.push_back(c + RD_LAT);
                    rt_b.push_back(issued[1:0]);
                end
                issued++;
                if (issued == 4) done_exp = c + 1 + (is_wr ? 0 : RD_LAT);
            end
            if (rt_c.size() > 0 && rt_c[0] == c) begin
                chk("rd_valid", rd_valid, 1'b1);
                chk("rd_beat", rd_beat, rt_b[0]);
                chk("rd_data", rd_data, mem_data_out);
                void'(rt_c.pop_front());
                void'(rt_b.pop_front());
            end else begin
                chk("rd_valid_idle", rd_valid, 1'b0);
            end
            sticky = sticky | mem_err;
            if (c == done_exp) begin
                chk("done", done, oh);
                chk("done_err", err, sticky ? oh : 2'b00);
                break;
            end else begin
                chk("no_done", done, 2'b00);
                chk("no_err", err, 2'b00);
            end
        end
        chk("done_seen", (done_c >= 0), 1'b1);
        mp = ~own;
    endtask

    initial begin
        rst = 1'b1; req_rd = 2'b00; req_wr = 2'b00; req_addr0 = 16'h0; req_addr1 = 16'h0;
        wr_data0 = 16'h0; wr_data1 = 16'h0; mem_data_out = 16'h0; mem_busy = 4'h0; mem_err = 1'b0;
        mp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention: requester 0 first, then 1, then 0 again
        run_txn(2'b10, 2'b01, 16'h1000, 16'h2008, 0, 0, -1, 0, 0, dc);
        chk("cont0_done_cycle", dc, 5);
        run_txn(2'b10, 2'b00, 16'h1000, 16'h2008, 0, 0, -1, 0, 0, dc);
        chk("cont1_done_cycle", dc, 7);
        run_txn(2'b10, 2'b01, 16'h3010, 16'h4018, 0, 0, -1, 0, 0, dc);
        chk("cont2_done_cycle", dc, 5);

        // Single read at 0x0128
        run_txn(2'b01, 2'b00, 16'h0128, 16'h0000, 0, 0, -1, 0, 0, dc);
        chk("rd_done_cycle", dc, 7);

        // Bank 2 busy for three cycles
        run_txn(2'b01, 2'b00, 16'h0240, 16'h0000, 0, 0, -1, 3, 0, dc);
        chk("busy_done_cycle", dc, 10);

        // Both request kinds from requester 1: error, no grant
        run_txn(2'b10, 2'b10, 16'h0000, 16'h0550, 0, 0, -1, 0, 0, dc);
        run_txn(2'b10, 2'b10, 16'h0000, 16'h0550, 0, 0, -1, 0, 0, dc);

        // Memory error during a write
        run_txn(2'b00, 2'b01, 16'h0660, 16'h0000, 0, 0, 2, 0, 0, dc);
        chk("werr_done_cycle", dc, 5);

        // Reset mid-read, then the pointer must favour requester 0 again
        run_txn(2'b01, 2'b00, 16'h0778, 16'h0000, 0, 0, -1, 0, 4, dc);
        run_txn(2'b11, 2'b00, 16'h0880, 16'h0990, 0, 0, -1, 0, 0, dc);

        for (int t = 0; t < 30; t++) begin
            run_txn(2'($urandom_range(3)), 2'($urandom_range(3)),
                    16'($urandom), 16'($urandom), 30, 5, -1, 0, 0, dc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
